sram_read_responder: RTL and testbench

//  Responder side of the accelerator's addr_t/idx_t read-request interface. Accepts tagged read

---
 rtl/sram_read_responder.sv | 138 +++++++++++++
 tb/tb_sram_read_responder.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/sram_read_responder.sv
// sram_read_responder: tagged in-order SRAM read responder with pad/error decode and credit flow control
// Ports: clk, rst_n (async active-low); req_valid/req_ready/req_addr/req_tag request handshake;
//   rsp_valid/rsp_ready/rsp_data/rsp_tag/rsp_err in-order response handshake;
//   sram_en/sram_addr/sram_rdata single-port SRAM read port (data RD_LAT cycles after sram_en);
//   flush stops acceptance and drains outstanding work; idle when nothing is outstanding.
// Optional ACCEL_RSP_PERF_EN adds perf_req_cnt/perf_pad_cnt/perf_err_cnt/perf_stall_cnt,
//   saturating counters cleared on a flush rising edge.
module sram_read_responder #(
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned MEM_DEPTH = 4096,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned RD_LAT    = 2,
  parameter int unsigned MAX_OUTST = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [31:0]                  req_addr,
  input  logic [7:0]                   req_tag,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [DATA_W-1:0]            rsp_data,
  output logic [7:0]                   rsp_tag,
  output logic                         rsp_err,
  output logic                         sram_en,
  output logic [$clog2(MEM_DEPTH)-1:0] sram_addr,
  input  logic [DATA_W-1:0]            sram_rdata,
  input  logic                         flush,
  output logic                         idle
`ifdef ACCEL_RSP_PERF_EN
  ,
  output logic [31:0]                  perf_req_cnt,
  output logic [31:0]                  perf_pad_cnt,
  output logic [31:0]                  perf_err_cnt,
  output logic [31:0]                  perf_stall_cnt
`endif
);
  localparam int unsigned AW = $clog2(MEM_DEPTH);
  localparam int unsigned BW = $clog2(DATA_W / 8);
  localparam int unsigned CW = $clog2(MAX_OUTST + 1);
  localparam int unsigned PW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam logic [32:0] MEM_BYTES = 33'(64'(MEM_DEPTH) * 64'(DATA_W / 8));
  localparam logic [31:0] NULL_ADDR = 32'h9999_9999;
  typedef enum logic {RUN, DRAIN} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, fcnt_q;
  logic [PW-1:0] wptr_q, rptr_q;
  logic [RD_LAT-1:0] pv_q, pz_q, pe_q;
  logic [7:0] pt_q [RD_LAT];
  logic [DATA_W-1:0] fd_q [MAX_OUTST];
  logic [7:0] ft_q [MAX_OUTST];
  logic [MAX_OUTST-1:0] fe_q;
  logic [31:0] off;
  logic pad, err, accept, rsp_hs, push;
  // Responses come straight from FIFO storage so they hold steady under backpressure;
  // req_ready is gated by rst_n so nothing is accepted while reset is asserted.
  always_comb begin
    off = req_addr - BASE_ADDR;
    pad = req_addr == NULL_ADDR;
    err = !pad && (req_addr < BASE_ADDR || {1'b0, off} >= MEM_BYTES || |(off & 32'(DATA_W / 8 - 1)));
    req_ready = rst_n && state_q == RUN && !flush && cnt_q < CW'(MAX_OUTST);
    accept = req_valid && req_ready;
    sram_en = accept && !pad && !err;
    sram_addr = sram_en ? AW'(off >> BW) : '0;
    rsp_valid = fcnt_q != '0;
    rsp_hs = rsp_valid && rsp_ready;
    rsp_data = rsp_valid ? fd_q[rptr_q] : '0;
    rsp_tag = rsp_valid ? ft_q[rptr_q] : '0;
    rsp_err = rsp_valid && fe_q[rptr_q];
    push = pv_q[RD_LAT-1];
    cnt_d = cnt_q + CW'(accept) - CW'(rsp_hs);
    idle = cnt_q == '0;
    state_d = state_q == RUN ? (flush ? DRAIN : RUN) : ((!flush && cnt_q == '0) ? RUN : DRAIN);
  end
  // Credits cover pipe plus FIFO, so a push never finds the FIFO full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q <= '0;
      fcnt_q <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      pv_q <= '0;
      pz_q <= '0;
      pe_q <= '0;
      fe_q <= '0;
      for (int i = 0; i < RD_LAT; i++) pt_q[i] <= '0;
      for (int i = 0; i < MAX_OUTST; i++) begin
        fd_q[i] <= '0;
        ft_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      fcnt_q <= fcnt_q + CW'(push) - CW'(rsp_hs);
      pv_q[0] <= accept;
      pz_q[0] <= pad || err;
      pe_q[0] <= err;
      pt_q[0] <= req_tag;
      for (int i = 1; i < RD_LAT; i++) begin
        pv_q[i] <= pv_q[i-1];
        pz_q[i] <= pz_q[i-1];
        pe_q[i] <= pe_q[i-1];
        pt_q[i] <= pt_q[i-1];
      end
      if (push) begin
        fd_q[wptr_q] <= pz_q[RD_LAT-1] ? '0 : sram_rdata;
        ft_q[wptr_q] <= pt_q[RD_LAT-1];
        fe_q[wptr_q] <= pe_q[RD_LAT-1];
        wptr_q <= (wptr_q == PW'(MAX_OUTST - 1)) ? '0 : wptr_q + 1'b1;
      end
      if (rsp_hs) rptr_q <= (rptr_q == PW'(MAX_OUTST - 1)) ? '0 : rptr_q + 1'b1;
    end
  end
`ifdef ACCEL_RSP_PERF_EN
  logic flush_q, clr;
  assign clr = flush && !flush_q;
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic inc);
    return (inc && v != '1) ? v + 32'd1 : v;
  endfunction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_q <= 1'b0;
      perf_req_cnt <= '0;
      perf_pad_cnt <= '0;
      perf_err_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      flush_q <= flush;
      perf_req_cnt <= clr ? '0 : sat_inc(perf_req_cnt, accept);
      perf_pad_cnt <= clr ? '0 : sat_inc(perf_pad_cnt, accept && pad);
      perf_err_cnt <= clr ? '0 : sat_inc(perf_err_cnt, accept && err);
      perf_stall_cnt <= clr ? '0 : sat_inc(perf_stall_cnt, rsp_valid && !rsp_ready);
    end
  end
`endif
endmodule

// File: tb/tb_sram_read_responder.sv
// tb_sram_read_responder: vector table, corner sequences and random traffic against a queue model
module tb_sram_read_responder;
  localparam logic [31:0] NULL_A = 32'h9999_9999;
  localparam logic [63:0] JUNK = 64'hBAD0_BAD0_BAD0_BAD0;
  logic clk, rst_n, req_valid, req_ready, rsp_valid, rsp_ready, rsp_err, sram_en, flush, idle;
  logic [31:0] req_addr;
  logic [7:0] req_tag, rsp_tag;
  logic [63:0] rsp_data, sram_rdata, s1, s2;
  logic [11:0] sram_addr;
  int total, bad, cyc, na, nacc, flen;
  bit a, drain;
  typedef struct {logic [63:0] data; logic [7:0] tag; logic err; int acc;} exp_t;
  typedef struct {logic [31:0] addr; logic [7:0] tag; logic en; logic [63:0] data; logic err;} vec_t;
  exp_t sb[$];
  vec_t tbl[8];

  sram_read_responder dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_tag(req_tag), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_tag(rsp_tag), .rsp_err(rsp_err), .sram_en(sram_en), .sram_addr(sram_addr),
    .sram_rdata(sram_rdata), .flush(flush), .idle(idle)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  function automatic logic [63:0] memval(input logic [11:0] w);
    return {52'h0, w} * 64'h9E37_79B9_7F4A_7C15 + 64'h1;
  endfunction

  function automatic bit addr_ok(input logic [31:0] x);
    return x != NULL_A && x < 32'h8000 && x[2:0] == 3'b0;
  endfunction

  // SRAM with two-cycle read latency; junk on cycles with no read so unmasked pads/errors show up
  always @(posedge clk) begin
    s1 <= sram_en ? memval(sram_addr) : JUNK;
    s2 <= s1;
  end
  assign sram_rdata = s2;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // One clock of the reference model: credits, drain mode, latency and in-order scoreboard
  task automatic tick();
    bit er, acc, hs;
    int n;
    #1;
    n = sb.size();
    er = !drain && !flush && n < 4;
    acc = req_valid && er;
    chk("req_ready", req_ready, er);
    chk("idle", idle, n == 0);
    chk("sram_en", sram_en, acc && addr_ok(req_addr));
    if (acc && addr_ok(req_addr)) chk("sram_addr", sram_addr, req_addr[14:3]);
    chk("rsp_valid", rsp_valid, (n > 0) ? (cyc >= sb[0].acc + 3) : 1'b0);
    hs = rsp_valid && rsp_ready && n > 0;
    if (hs) begin
      chk("rsp_data", rsp_data, sb[0].data);
      chk("rsp_tag", rsp_tag, sb[0].tag);
      chk("rsp_err", rsp_err, sb[0].err);
      void'(sb.pop_front());
    end
    if (acc) sb.push_back('{addr_ok(req_addr) ? memval(req_addr[14:3]) : 64'h0, req_tag,
                           req_addr != NULL_A && !addr_ok(req_addr), cyc});
    drain = flush || (drain && n != 0);
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic rst_chk(input string nm);
    chk({nm, " req_ready"}, req_ready, 0);
    chk({nm, " rsp_valid"}, rsp_valid, 0);
    chk({nm, " rsp_data"}, rsp_data, 0);
    chk({nm, " rsp_tag"}, rsp_tag, 0);
    chk({nm, " rsp_err"}, rsp_err, 0);
    chk({nm, " sram_en"}, sram_en, 0);
    chk({nm, " sram_addr"}, sram_addr, 0);
    chk({nm, " idle"}, idle, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 0; req_valid = 0; req_addr = 0; req_tag = 0; rsp_ready = 0; flush = 0; drain = 0;
    total = 0; bad = 0; cyc = 0;
    @(negedge clk);
    @(negedge clk);
    rst_chk("init");
    rst_n = 1;
    #1 chk("ready after reset", req_ready, 1);

    tbl[0] = '{32'h0000_0010, 8'h05, 1'b1, memval(12'd2), 1'b0};
    tbl[1] = '{NULL_A, 8'hA0, 1'b0, 64'h0, 1'b0};
    tbl[2] = '{32'h0000_0003, 8'h11, 1'b0, 64'h0, 1'b1};
    tbl[3] = '{32'h0000_8000, 8'h12, 1'b0, 64'h0, 1'b1};
    tbl[4] = '{32'h0000_7FF8, 8'h13, 1'b1, memval(12'hFFF), 1'b0};
    tbl[5] = '{32'h0000_0000, 8'h14, 1'b1, memval(12'h000), 1'b0};
    tbl[6] = '{32'h0000_0004, 8'h15, 1'b0, 64'h0, 1'b1};
    tbl[7] = '{32'hFFFF_FFF8, 8'h16, 1'b0, 64'h0, 1'b1};
    for (int i = 0; i < 8; i++) begin
      req_valid = 1; req_addr = tbl[i].addr; req_tag = tbl[i].tag; rsp_ready = 1;
      #1 chk("vec sram_en", sram_en, tbl[i].en);
      tick();
      req_valid = 0;
      tick();
      tick();
      #1;
      chk("vec rsp_valid", rsp_valid, 1);
      chk("vec rsp_data", rsp_data, tbl[i].data);
      chk("vec rsp_tag", rsp_tag, tbl[i].tag);
      chk("vec rsp_err", rsp_err, tbl[i].err);
      tick();
    end

    // back-to-back error requests return in order
    req_valid = 1; req_addr = 32'h3; req_tag = 8'h21;
    tick();
    req_addr = 32'h8000; req_tag = 8'h22;
    tick();
    req_valid = 0;
    for (int i = 0; i < 6; i++) tick();

    // backpressure: only four credits
    rsp_ready = 0; na = 0;
    for (int i = 0; i < 6; i++) begin
      req_valid = 1; req_addr = 32'h100 + 32'(8 * na); req_tag = 8'(8'h40 + na);
      #1 a = req_ready;
      tick();
      if (a) na++;
    end
    chk("bp accepted", na, 4);
    #1 chk("bp req_ready", req_ready, 0);
    rsp_ready = 1;
    for (int i = 0; i < 40 && (na < 6 || sb.size() > 0); i++) begin
      req_valid = na < 6; req_addr = 32'h100 + 32'(8 * na); req_tag = 8'(8'h40 + na);
      #1 a = req_ready && req_valid;
      tick();
      if (a) na++;
    end
    req_valid = 0;
    chk("bp all accepted", na, 6);
    chk("bp drained", sb.size(), 0);

    // flush with three outstanding and a request held
    rsp_ready = 0;
    for (int i = 0; i < 3; i++) begin
      req_valid = 1; req_addr = 32'h200 + 32'(8 * i); req_tag = 8'(8'h60 + i);
      tick();
    end
    flush = 1; req_addr = 32'h300; req_tag = 8'h70; nacc = 0;
    for (int i = 0; i < 2; i++) begin
      #1 if (req_ready) nacc++;
      tick();
    end
    rsp_ready = 1;
    for (int i = 0; i < 20 && !idle; i++) begin
      #1 if (req_ready) nacc++;
      tick();
    end
    chk("flush accepted", nacc, 0);
    chk("flush idle", idle, 1);
    chk("flush drained", sb.size(), 0);
    flush = 0;
    tick();
    #1 chk("run after flush", req_ready, 1);
    for (int i = 0; i < 6; i++) begin
      tick();
      req_valid = 0;
    end

    // reset mid-traffic
    rsp_ready = 0;
    for (int i = 0; i < 5; i++) begin
      req_valid = 1; req_addr = 32'h400 + 32'(8 * i); req_tag = 8'(8'h80 + i);
      tick();
    end
    rst_n = 0;
    #1 rst_chk("mid reset");
    @(negedge clk);
    rst_chk("held reset");
    sb.delete(); drain = 0;
    rst_n = 1; req_valid = 0; rsp_ready = 1;
    for (int i = 0; i < 8; i++) tick();
    req_valid = 1; req_addr = 32'h48; req_tag = 8'h99;
    tick();
    req_valid = 0;
    for (int i = 0; i < 5; i++) tick();

    // random traffic
    flen = 0;
    for (int i = 0; i < 600; i++) begin
      req_valid = $urandom_range(0, 9) < 7;
      case ($urandom_range(0, 5))
        0: req_addr = NULL_A;
        1: req_addr = 32'($urandom_range(0, 32767)) | 32'h1;
        2: req_addr = ($urandom | 32'h8000) & ~32'h7;
        default: req_addr = {17'h0, 12'($urandom_range(0, 4095)), 3'b0};
      endcase
      req_tag = 8'($urandom);
      rsp_ready = $urandom_range(0, 9) < 7;
      if (flen > 0) flen--;
      else if ($urandom_range(0, 99) < 3) flen = $urandom_range(1, 6);
      flush = flen > 0;
      tick();
    end
    flush = 0; req_valid = 0; rsp_ready = 1;
    for (int i = 0; i < 50 && sb.size() > 0; i++) tick();
    chk("final drained", sb.size(), 0);
    tick();
    #1 chk("final idle", idle, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
